// File: rtl/noc_tg_pkg.sv
// Shared encodings for the synthetic-traffic PE: pattern modes, FSM states,
// payload field layout and the LFSR feedback polynomial.
package noc_tg_pkg;

  typedef enum logic [1:0] {
    MODE_RANDOM    = 2'd0,
    MODE_TRANSPOSE = 2'd1,
    MODE_BITCOMP   = 2'd2,
    MODE_HOTSPOT   = 2'd3
  } tg_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } tg_state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Payload field offsets, relative to the payload LSB (above the dest fields)
  localparam int PL_SRCX_LSB  = 0;
  localparam int PL_SRCY_LSB  = 8;
  localparam int PL_SRC_W     = 8;
  localparam int PL_SEQ_LSB   = 16;
  localparam int PL_SEQ_W     = 16;
  localparam int PL_STAMP_LSB = 32;
  localparam int PL_STAMP_W   = 32;

endpackage

// File: rtl/noc_traffic_pe_if.sv
// Local-port flit bus between a traffic PE (master) and its router (slave).
interface noc_traffic_pe_if #(
  parameter int TW = 258
) ();
  logic [TW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic [TW-1:0] i_data;
  logic          i_valid;

  modport master (output o_data, output o_valid, input i_ready, input i_data, input i_valid);
  modport slave  (input o_data, input o_valid, output i_ready, output i_data, output i_valid);
endinterface

// File: rtl/noc_lfsr32.sv
// 32-bit Galois LFSR; seed loaded on reset, advances only while en_i is high.
module noc_lfsr32
  import noc_tg_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en_i,
  output logic [31:0] lfsr_o
);
  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;
endmodule

// File: rtl/noc_traffic_pe.sv
// Synthetic-traffic PE: injects num_of_pckts flits in a selectable pattern and sinks/checks
// incoming flits. Define TG_LATENCY_STATS_EN for in-band timestamping and latency statistics.
//
// state   | meaning
// IDLE    | waiting for start; mode/rate latched when it arrives
// GEN     | LFSR stepping; draws a destination and rate-gates injection
// SEND    | flit held on o_data with o_valid until i_ready
// FIN     | all packets accepted (or nothing to send); done held until reset
module noc_traffic_pe
  import noc_tg_pkg::*;
#(
  parameter int          X            = 2,
  parameter int          Y            = 2,
  parameter int          xcord        = 0,
  parameter int          ycord        = 0,
  parameter int          data_width   = 256,
  parameter int          x_size       = 1,
  parameter int          y_size       = 1,
  parameter int          total_width  = x_size + y_size + data_width,
  parameter int          num_of_pckts = 100,
  parameter int          HOT_X        = 0,
  parameter int          HOT_Y        = 0,
  parameter logic [31:0] SEED         = 32'hACE1_0001
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  enableSend,
  input  logic [1:0]            i_mode,
  input  logic [7:0]            i_rate,
  noc_traffic_pe_if.master      bus,
  output logic                  done,
  output logic [31:0]           sentPktCount,
  output logic [31:0]           receivedPktCount,
  output logic [15:0]           errCount,
  output logic [47:0]           latSum,
  output logic [31:0]           latMax
);
  localparam logic [31:0] SEED_EFF = SEED ^ {16'(ycord), 16'(xcord)};
  localparam int NREP = (data_width + 31) / 32;
  localparam bit TR_OK    = (X == Y) && (xcord != ycord) && (ycord < X) && (xcord < Y);
  localparam bit BC_OK    = !(((X - 1 - xcord) == xcord) && ((Y - 1 - ycord) == ycord));
  localparam bit HOT_SELF = (HOT_X == xcord) && (HOT_Y == ycord);
  localparam bit RND_OK   = (X * Y) > 1;

  tg_state_e               state_q, state_d;
  tg_mode_e                mode_q, mode_d, mode_sel;
  logic [7:0]              rate_q, rate_d;
  logic [31:0]             sent_q, sent_d;
  logic [total_width-1:0]  data_q, data_d;
  logic [31:0]             recv_q, recv_d;
  logic [15:0]             err_q, err_d;
  logic [31:0]             lfsr_q, stamp;
  logic                    lfsr_en;
  logic [x_size-1:0]       rnd_x, dst_x;
  logic [y_size-1:0]       rnd_y, dst_y;
  logic                    rnd_ok, dst_ok, mode_possible, inject;
  logic [NREP*32-1:0]      fill;
  logic [data_width-1:0]   payload;
  logic                    rx_mis;
  logic                    unused_ok;

  noc_lfsr32 #(.SEED(SEED_EFF)) u_lfsr (
    .clk    (clk),
    .rstn   (rstn),
    .en_i   (lfsr_en),
    .lfsr_o (lfsr_q)
  );

  // Destination selection; in IDLE the live i_mode decides whether a run can send at all
  always_comb begin
    mode_sel      = (state_q == ST_IDLE) ? tg_mode_e'(i_mode) : mode_q;
    rnd_x         = lfsr_q[x_size+8 +: x_size];
    rnd_y         = lfsr_q[y_size+16 +: y_size];
    rnd_ok        = (int'(rnd_x) < X) && (int'(rnd_y) < Y) &&
                    !((int'(rnd_x) == xcord) && (int'(rnd_y) == ycord));
    dst_x         = rnd_x;
    dst_y         = rnd_y;
    dst_ok        = rnd_ok;
    mode_possible = RND_OK;
    case (mode_sel)
      MODE_TRANSPOSE: begin
        dst_x         = x_size'(ycord);
        dst_y         = y_size'(xcord);
        dst_ok        = TR_OK;
        mode_possible = TR_OK;
      end
      MODE_BITCOMP: begin
        dst_x         = x_size'(X - 1 - xcord);
        dst_y         = y_size'(Y - 1 - ycord);
        dst_ok        = BC_OK;
        mode_possible = BC_OK;
      end
      MODE_HOTSPOT: begin
        if (!HOT_SELF) begin
          dst_x         = x_size'(HOT_X);
          dst_y         = y_size'(HOT_Y);
          dst_ok        = 1'b1;
          mode_possible = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    fill    = {NREP{lfsr_q}};
    payload = fill[data_width-1:0];
    payload[PL_SRCX_LSB  +: PL_SRC_W]   = 8'(xcord);
    payload[PL_SRCY_LSB  +: PL_SRC_W]   = 8'(ycord);
    payload[PL_SEQ_LSB   +: PL_SEQ_W]   = sent_q[15:0];
    payload[PL_STAMP_LSB +: PL_STAMP_W] = stamp;
  end

  assign inject = ((rate_q == 8'hFF) || (lfsr_q[7:0] < rate_q)) && dst_ok;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rate_d  = rate_q;
    sent_d  = sent_q;
    data_d  = data_q;
    lfsr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = tg_mode_e'(i_mode);
          rate_d = i_rate;
          if ((num_of_pckts == 0) || !enableSend || !mode_possible) state_d = ST_FIN;
          else                                                      state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        lfsr_en = 1'b1;
        if (inject) begin
          data_d  = {payload, dst_y, dst_x};
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.i_ready) begin
          sent_d  = sent_q + 32'd1;
          state_d = (sent_q + 32'd1 == 32'(num_of_pckts)) ? ST_FIN : ST_GEN;
        end
      end
      default: ;
    endcase
  end

  assign rx_mis = (bus.i_data[x_size-1:0] != x_size'(xcord)) ||
                  (bus.i_data[x_size +: y_size] != y_size'(ycord));

  always_comb begin
    recv_d = recv_q;
    err_d  = err_q;
    if (bus.i_valid) begin
      recv_d = recv_q + 32'd1;
      if (rx_mis && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_RANDOM;
      rate_q  <= '0;
      sent_q  <= '0;
      data_q  <= '0;
      recv_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rate_q  <= rate_d;
      sent_q  <= sent_d;
      data_q  <= data_d;
      recv_q  <= recv_d;
      err_q   <= err_d;
    end
  end

`ifdef TG_LATENCY_STATS_EN
  logic [31:0] cyc_q, lat_q, latmax_q, rx_stamp;
  logic        lat_vld_q;
  logic [47:0] latsum_q;

  assign rx_stamp = bus.i_data[x_size+y_size+PL_STAMP_LSB +: PL_STAMP_W];

  // Latency is captured on the receive cycle and folded into the stats one cycle later
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_q     <= '0;
      lat_q     <= '0;
      lat_vld_q <= 1'b0;
      latsum_q  <= '0;
      latmax_q  <= '0;
    end else begin
      cyc_q     <= cyc_q + 32'd1;
      lat_vld_q <= bus.i_valid;
      if (bus.i_valid) lat_q <= cyc_q - rx_stamp;
      if (lat_vld_q) begin
        latsum_q <= latsum_q + {16'd0, lat_q};
        if (lat_q > latmax_q) latmax_q <= lat_q;
      end
    end
  end

  assign stamp  = cyc_q;
  assign latSum = latsum_q;
  assign latMax = latmax_q;
`else
  assign stamp  = lfsr_q;
  assign latSum = '0;
  assign latMax = '0;
`endif

  assign unused_ok        = ^bus.i_data[total_width-1:x_size+y_size];
  assign bus.o_valid      = (state_q == ST_SEND);
  assign bus.o_data       = data_q;
  assign done             = (state_q == ST_FIN);
  assign sentPktCount     = sent_q;
  assign receivedPktCount = recv_q;
  assign errCount         = err_q;
endmodule

// File: tb/tb_noc_traffic_pe.sv
// Directed bench for a single noc_traffic_pe at mesh position (0,0) of a 2x2 mesh.
module tb_noc_traffic_pe;
  localparam int DW  = 64;
  localparam int TW  = DW + 2;
  localparam int NUM = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        enableSend = 1'b0;
  logic [1:0]  i_mode = 2'd0;
  logic [7:0]  i_rate = 8'd0;
  logic        done;
  logic [31:0] sent, recv;
  logic [15:0] errc;
  logic [47:0] lsum;
  logic [31:0] lmax;
  int checks = 0;
  int failures = 0;

  noc_traffic_pe_if #(.TW(TW)) bus ();

  noc_traffic_pe #(
    .X(2), .Y(2), .xcord(0), .ycord(0), .data_width(DW), .x_size(1), .y_size(1),
    .num_of_pckts(NUM), .HOT_X(1), .HOT_Y(0)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .enableSend(enableSend),
    .i_mode(i_mode), .i_rate(i_rate), .bus(bus), .done(done),
    .sentPktCount(sent), .receivedPktCount(recv), .errCount(errc),
    .latSum(lsum), .latMax(lmax)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    start = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge following the IDLE->(GEN|FIN) edge
  task automatic start_run(input logic [1:0] m, input logic [7:0] r, input logic en);
    i_mode = m;
    i_rate = r;
    enableSend = en;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input logic [1:0] exp_dest, input bit fixed);
    int  nsent = 0;
    bit  seen_done = 1'b0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      if (bus.o_valid === 1'b1) begin
        if (fixed) check({tag, "_dest"}, bus.o_data[1:0], exp_dest);
        else       check({tag, "_dest_not_self"}, bus.o_data[1:0] != 2'b00, 1);
        check({tag, "_src"}, bus.o_data[17:2], 0);
        check({tag, "_seq"}, bus.o_data[33:18], nsent);
        nsent++;
      end
      if (done === 1'b1) seen_done = 1'b1;
      else               @(negedge clk);
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_sent"}, sent, NUM);
    check({tag, "_flits"}, nsent, NUM);
    @(negedge clk);
    check({tag, "_valid_after_done"}, bus.o_valid, 0);
  endtask

  initial begin
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data = '0;
    repeat (2) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_data", bus.o_data[63:0], 0);
    check("rst_sent", sent, 0);
    check("rst_recv", recv, 0);
    check("rst_err", errc, 0);
    check("rst_latsum", lsum, 0);
    check("rst_latmax", lmax, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Fixed-destination patterns at full rate
    start_run(2'd2, 8'hFF, 1'b1);
    run_to_done("bitcomp", 2'b11, 1'b1);
    do_reset();
    start_run(2'd3, 8'hFF, 1'b1);
    run_to_done("hotspot", 2'b01, 1'b1);
    do_reset();
    start_run(2'd0, 8'hFF, 1'b1);
    run_to_done("random", 2'b00, 1'b0);

    // Transpose on a diagonal PE has nowhere to send
    do_reset();
    start_run(2'd1, 8'hFF, 1'b1);
    check("transpose_done", done, 1);
    check("transpose_sent", sent, 0);
    repeat (3) @(negedge clk);
    check("transpose_valid", bus.o_valid, 0);

    // enableSend low, then start ignored while in FIN
    do_reset();
    start_run(2'd2, 8'hFF, 1'b0);
    check("nosend_done", done, 1);
    check("nosend_valid", bus.o_valid, 0);
    start_run(2'd2, 8'hFF, 1'b1);
    repeat (3) @(negedge clk);
    check("fin_restart_valid", bus.o_valid, 0);
    check("fin_restart_sent", sent, 0);
    check("fin_restart_done", done, 1);

    // Rate threshold 0 never injects
    do_reset();
    start_run(2'd0, 8'h00, 1'b1);
    repeat (20) @(negedge clk);
    check("rate0_valid", bus.o_valid, 0);
    check("rate0_sent", sent, 0);
    check("rate0_done", done, 0);

    // Back-pressure: flit held stable, then accepted on release
    do_reset();
    bus.i_ready = 1'b0;
    start_run(2'd2, 8'hFF, 1'b1);
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      check("stall_valid", bus.o_valid, 1);
      check("stall_head", bus.o_data[33:0], 34'h3);
      check("stall_sent", sent, 0);
      @(negedge clk);
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    check("release_sent", sent, 1);
    check("release_valid", bus.o_valid, 0);
    @(negedge clk);
    check("second_valid", bus.o_valid, 1);
    check("second_seq", bus.o_data[33:18], 1);
    bus.i_ready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("midrst_valid", bus.o_valid, 0);
    check("midrst_data", bus.o_data[63:0], 0);
    check("midrst_sent", sent, 0);
    check("midrst_done", done, 0);

    // Receive path: misrouted flit, good flit, then receive concurrent with injection
    do_reset();
    bus.i_valid = 1'b1;
    bus.i_data = 66'h3;
    @(negedge clk);
    check("mis_recv", recv, 1);
    check("mis_err", errc, 1);
    bus.i_data = 66'h0;
    @(negedge clk);
    check("good_recv", recv, 2);
    check("good_err", errc, 1);
    start_run(2'd2, 8'hFF, 1'b1);
    @(negedge clk);
    check("concurrent_valid", bus.o_valid, 1);
    @(negedge clk);
    check("concurrent_recv", recv, 5);
    check("concurrent_sent", sent, 1);
    check("concurrent_err", errc, 1);
    bus.i_valid = 1'b0;
    @(negedge clk);
    check("idle_rx_recv", recv, 5);
    check("end_latsum", lsum, 0);
    check("end_latmax", lmax, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
